// File: rtl/dig_inp_pkg.sv
// Shared types and constants for the scanned digital-input debounce controller.
package dig_inp_pkg;

  localparam int EVT_FIFO_DEPTH     = 4;
  localparam int DEFAULT_FILTER_VAL = 25;
  // Wide enough for the largest supported bank (32 channels)
  localparam int EVT_CH_W           = 5;

  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                level;
  } evt_t;

endpackage

// File: rtl/dig_inp_evt_fifo.sv
// Event buffer with valid/ready output, drop-on-full and sticky overflow flag.
// DEPTH=1 degenerates to a single holding register with the same rules.
module dig_inp_evt_fifo
  import dig_inp_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic push_i,
  input  evt_t push_evt_i,
  input  logic ready_i,
  input  logic ovf_clr_i,
  output logic valid_o,
  output evt_t evt_o,
  output logic ovf_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  evt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             pop, full, push_ok, drop;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop     = ready_i && (cnt_q != '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a full buffer still accepts
  assign push_ok = push_i && (!full || pop);
  assign drop    = push_i && full && !pop;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_evt_i;
        wr_q        <= ptr_nxt(wr_q);
      end
      if (pop) rd_q <= ptr_nxt(rd_q);
      if (push_ok && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push_ok && pop) cnt_q <= cnt_q - CNT_W'(1);
      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign evt_o   = mem_q[rd_q];
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/dig_inp_scan_ctrl.sv
// Round-robin debounce of CHANNELS inputs through one shared counter/compare path.
// Define DIG_INP_SCAN_EVT_FIFO_EN for a 4-deep event FIFO; otherwise depth 1.
module dig_inp_scan_ctrl
  import dig_inp_pkg::*;
#(
  parameter int CHANNELS       = 8,
  parameter int CTR_W          = 5,
  parameter int DEFAULT_FILTER = DEFAULT_FILTER_VAL,
  parameter int PRESCALE       = 16,
  localparam int AW            = $clog2(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] in_i,
  input  logic                cfg_we_i,
  input  logic [AW-1:0]       cfg_addr_i,
  input  logic [CTR_W-1:0]    cfg_data_i,
  input  logic                ovf_clr_i,
  output logic [CHANNELS-1:0] out_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [AW-1:0]       evt_ch_o,
  output logic                evt_level_o,
  output logic                evt_ovf_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW1   = AW + 1;
`ifdef DIG_INP_SCAN_EVT_FIFO_EN
  localparam int EVT_DEPTH = EVT_FIFO_DEPTH;
`else
  localparam int EVT_DEPTH = 1;
`endif

  logic [CHANNELS-1:0] sync1_q, sync2_q, out_q, out_d;
  logic [PRE_W-1:0]    pre_q;
  logic [AW-1:0]       ptr_q;
  logic [CTR_W-1:0]    ctr_q [CHANNELS];
  logic [CTR_W-1:0]    ctr_d [CHANNELS];
  logic [CTR_W-1:0]    thr_q [CHANNELS];
  logic [CTR_W-1:0]    thr_d [CHANNELS];
  logic [CTR_W-1:0]    cur_ctr, cur_thr, ctr_inc;
  logic                visit, cfg_hit;
  logic                ev_push_q, ev_push_d;
  evt_t                ev_q, ev_d, ev_out;
  logic                unused_ch_hi;

  always_comb begin
    visit     = (pre_q == PRE_W'(PRESCALE - 1));
    cfg_hit   = cfg_we_i && ({1'b0, cfg_addr_i} < AW1'(CHANNELS));
    cur_ctr   = ctr_q[ptr_q];
    cur_thr   = thr_q[ptr_q];
    ctr_inc   = cur_ctr + CTR_W'(1);
    ctr_d     = ctr_q;
    thr_d     = thr_q;
    out_d     = out_q;
    ev_push_d = 1'b0;
    ev_d      = '0;
    // A config write to the channel being visited takes priority over the visit
    if (visit && !(cfg_hit && cfg_addr_i == ptr_q) && cur_thr != '0) begin
      if (sync2_q[ptr_q] == out_q[ptr_q]) begin
        ctr_d[ptr_q] = '0;
      end else if (ctr_inc == cur_thr) begin
        out_d[ptr_q] = sync2_q[ptr_q];
        ctr_d[ptr_q] = '0;
        ev_push_d    = 1'b1;
        ev_d.ch      = EVT_CH_W'(ptr_q);
        ev_d.level   = sync2_q[ptr_q];
      end else begin
        ctr_d[ptr_q] = ctr_inc;
      end
    end
    if (cfg_hit) begin
      thr_d[cfg_addr_i] = cfg_data_i;
      ctr_d[cfg_addr_i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_q     <= '0;
      ptr_q     <= '0;
      out_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ctr_q[i] <= '0;
        thr_q[i] <= CTR_W'(DEFAULT_FILTER);
      end
      ev_push_q <= 1'b0;
      ev_q      <= '0;
    end else begin
      sync1_q   <= in_i;
      sync2_q   <= sync1_q;
      pre_q     <= visit ? '0 : pre_q + PRE_W'(1);
      if (visit) ptr_q <= (ptr_q == AW'(CHANNELS - 1)) ? '0 : ptr_q + AW'(1);
      out_q     <= out_d;
      ctr_q     <= ctr_d;
      thr_q     <= thr_d;
      // Staging register: the event reaches the buffer one clock after OUT moves
      ev_push_q <= ev_push_d;
      ev_q      <= ev_d;
    end
  end

  dig_inp_evt_fifo #(.DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (ev_push_q),
    .push_evt_i (ev_q),
    .ready_i    (evt_ready_i),
    .ovf_clr_i  (ovf_clr_i),
    .valid_o    (evt_valid_o),
    .evt_o      (ev_out),
    .ovf_o      (evt_ovf_o)
  );

  assign out_o        = out_q;
  assign evt_ch_o     = ev_out.ch[AW-1:0];
  assign evt_level_o  = ev_out.level;
  assign unused_ch_hi = ^ev_out.ch;

endmodule

// File: tb/tb_dig_inp_scan_ctrl.sv
// Randomized bench for dig_inp_scan_ctrl against a visit-schedule reference model.
module tb_dig_inp_scan_ctrl;

  localparam int C  = 5;
  localparam int CW = 5;
  localparam int DF = 3;
  localparam int P  = 2;
  localparam int AW = $clog2(C);
`ifdef DIG_INP_SCAN_EVT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [C-1:0]  in_r;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          ovf_clr;
  logic          evt_ready;
  logic [C-1:0]  out_w;
  logic          evt_valid;
  logic [AW-1:0] evt_ch;
  logic          evt_level;
  logic          evt_ovf;

  always #5 clk = ~clk;

  dig_inp_scan_ctrl #(
    .CHANNELS(C), .CTR_W(CW), .DEFAULT_FILTER(DF), .PRESCALE(P)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_i        (in_r),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .ovf_clr_i   (ovf_clr),
    .out_o       (out_w),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_ch_o    (evt_ch),
    .evt_level_o (evt_level),
    .evt_ovf_o   (evt_ovf)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: visits derived from elapsed clocks since reset
  typedef struct { int ch; bit lvl; } mev_t;
  mev_t         mq [$];
  mev_t         pend;
  bit           pend_v;
  bit           m_ovf;
  bit           m_in_rst;
  logic [C-1:0] m_out, hist1, hist2;
  int           m_thr [C];
  int           m_run [C];
  int           n_clk;

  task automatic model_edge();
    bit pop, drop, cfg_ok;
    int vch;
    logic [C-1:0] sin;
    if (!rst_n) begin
      mq.delete();
      pend_v = 0; m_ovf = 0; m_in_rst = 1;
      m_out = '0; hist1 = '0; hist2 = '0; n_clk = 0;
      for (int i = 0; i < C; i++) begin m_thr[i] = DF; m_run[i] = 0; end
      return;
    end
    m_in_rst = 0;
    pop = evt_ready && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    drop = 0;
    if (pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(pend);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    sin    = hist2;
    vch    = (n_clk / P) % C;
    cfg_ok = cfg_we && (int'(cfg_addr) < C);
    pend_v = 0;
    if ((n_clk % P == P - 1) && !(cfg_ok && int'(cfg_addr) == vch) && m_thr[vch] != 0) begin
      if (sin[vch] == m_out[vch]) m_run[vch] = 0;
      else if (m_run[vch] + 1 == m_thr[vch]) begin
        m_out[vch]  = sin[vch];
        m_run[vch]  = 0;
        pend_v      = 1;
        pend.ch     = vch;
        pend.lvl    = sin[vch];
      end else m_run[vch]++;
    end
    if (cfg_ok) begin
      m_thr[cfg_addr] = int'(cfg_data);
      m_run[cfg_addr] = 0;
    end
    hist2 = hist1;
    hist1 = in_r;
    n_clk++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", out_w, m_out);
    chk("valid", evt_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("ch", evt_ch, mq[0].ch);
      chk("level", evt_level, mq[0].lvl);
    end else if (m_in_rst) begin
      chk("rst_ch", evt_ch, 0);
      chk("rst_level", evt_level, 0);
    end
    chk("ovf", evt_ovf, m_ovf);
  endtask

  task automatic drive(input int tog_div, input int rdy_pct, input int cfg_div,
                       input int rst_div, input int clr_pct);
    for (int i = 0; i < C; i++)
      if (tog_div > 0 && $urandom_range(tog_div - 1) == 0) in_r[i] = ~in_r[i];
    evt_ready = ($urandom_range(99) < rdy_pct);
    cfg_we    = (cfg_div > 0) && ($urandom_range(cfg_div - 1) == 0);
    cfg_addr  = AW'($urandom_range((1 << AW) - 1));
    cfg_data  = CW'($urandom_range(4));
    rst_n     = !((rst_div > 0) && ($urandom_range(rst_div - 1) == 0));
    ovf_clr   = ($urandom_range(99) < clr_pct);
  endtask

  initial begin
    rst_n = 0; in_r = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    ovf_clr = 0; evt_ready = 0;
    step();
    step();
    rst_n = 1;
    // Slow, clean level changes with an always-ready consumer
    for (int k = 0; k < 600; k++) begin drive(60, 100, 0, 0, 0); step(); end
    // Stalled consumer: buffer fills and events get dropped
    for (int k = 0; k < 500; k++) begin drive(25, 3, 0, 0, 1); step(); end
    // One-cycle reset with pending events and runs in flight
    rst_n = 0; cfg_we = 0; evt_ready = 0; ovf_clr = 0;
    step();
    rst_n = 1;
    for (int k = 0; k < 40; k++) begin drive(0, 0, 0, 0, 0); step(); end
    // Frequent threshold rewrites (including 0 and 1), some landing on visits
    for (int k = 0; k < 800; k++) begin drive(40, 50, 6, 0, 5); step(); end
    // Everything mixed, including random resets
    for (int k = 0; k < 1200; k++) begin drive(35, 40, 20, 300, 5); step(); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dig_inp_scan_ctrl.md
# dig_inp_scan_ctrl

Time-multiplexed debounce controller for a bank of digital inputs. One shared counter/compare datapath is scheduled round-robin across `CHANNELS` inputs, with per-channel filter thresholds written over a config port. Each debounced level change is reported as an event on a valid/ready stream. Sits between the raw field inputs and the register/interrupt logic; replaces per-pin free-running filter instances.

## Interface
- `CHANNELS`, 8: number of inputs; range 2..32.
- `CTR_W`, 5: width of the per-channel counter and threshold.
- `DEFAULT_FILTER`, 25: threshold loaded at reset.
- `PRESCALE`, 16: clocks per scan step; must be ≥1.
- `CLK` in 1: single clock.
- `RST_N` in 1: synchronous reset, active-low.
- `IN` in CHANNELS: raw asynchronous inputs.
- `CFG_WE` in 1: threshold write strobe.
- `CFG_ADDR` in clog2(CHANNELS): channel to configure.
- `CFG_DATA` in CTR_W: new threshold.
- `OVF_CLR` in 1: clears `EVT_OVF`.
- `OUT` out CHANNELS: debounced levels.
- `EVT_VALID` out 1: event available.
- `EVT_READY` in 1: consumer accepts the event.
- `EVT_CH` out clog2(CHANNELS): channel of the event.
- `EVT_LEVEL` out 1: new level of that channel.
- `EVT_OVF` out 1: sticky flag, an event was dropped.

## Operation
- Each `IN` bit passes through a 2-flop synchronizer, reset to 0. `sin[i]` is the synchronized level.
- Prescaler counts 0..PRESCALE-1 and wraps. A **visit** is the cycle where the prescaler equals PRESCALE-1. Channel `ptr` is processed on a visit; then `ptr` increments and wraps CHANNELS-1 → 0.
- Visit of channel i, with `ctr[i]` and `thr[i]`:
  - `thr[i]==0`: channel disabled. `ctr[i]` stays 0, `OUT[i]` is frozen, no event.
  - `sin[i]==OUT[i]`: `ctr[i]` is cleared to 0. Any mismatch run is aborted.
  - Mismatch and `ctr[i]+1 < thr[i]`: `ctr[i]` increments.
  - Mismatch and `ctr[i]+1 == thr[i]`: `OUT[i]` takes `sin[i]`, `ctr[i]` is cleared, and event {i, sin[i]} is pushed.
- A level change therefore needs `thr[i]` consecutive mismatching visits.
- Counter arithmetic is CTR_W wide. Reaching the threshold is checked before any wrap, so `ctr` never exceeds `thr-1`.
- Config write (`CFG_WE`):
  - Loads `thr[CFG_ADDR]` and clears `ctr[CFG_ADDR]`.
  - `CFG_ADDR ≥ CHANNELS`: the write is ignored.
  - Write on the same cycle as a visit to the same channel: the config wins. `ctr` is cleared, `OUT` is unchanged, no event.
- Event stream:
  - A transfer happens when `EVT_VALID && EVT_READY`.
  - `EVT_CH` and `EVT_LEVEL` stay stable while `EVT_VALID && !EVT_READY`.
  - A push when the buffer is full drops the new event and sets `EVT_OVF`.
  - A push and a pop on the same cycle when full: the push is accepted.
  - `OVF_CLR` clears `EVT_OVF`. If `OVF_CLR` coincides with a drop, set wins.

## Timing
- Reset values: `OUT=0`, all `ctr=0`, all `thr=DEFAULT_FILTER`, `ptr=0`, prescaler 0, synchronizers 0, `EVT_VALID=0`, `EVT_CH=0`, `EVT_LEVEL=0`, `EVT_OVF=0`, buffer empty.
- `RST_N` asserted mid-run aborts all counts and flushes pending events the same cycle.
- `OUT[i]` changes on the clock edge that ends the deciding visit.
- `EVT_VALID` rises one cycle later: the buffer output is registered.
- Worst-case input-to-`OUT` latency: 2 + PRESCALE·CHANNELS·thr clocks.
- Scan period is exactly PRESCALE·CHANNELS clocks.

## Configuration
- `DIG_INP_SCAN_EVT_FIFO_EN` defined: the event buffer is a 4-entry FIFO.
- Not defined: the event buffer is a single holding register, depth 1, with the same full/drop/overflow rules.

## Structure
- Shared package `dig_inp_pkg` holds:
  - event record type {ch, level};
  - FIFO depth constant (4);
  - `DEFAULT_FILTER` default value.
- Sub-module `dig_inp_evt_fifo`, parameterized depth (1 or 4), handles the valid/ready, full and overflow logic.
- `ctr` and `thr` are register arrays indexed by `ptr`; there is one shared increment/compare path.

## Test plan
- CHANNELS=4, PRESCALE=2, thr=3; `IN[1]` 0→1 held → `OUT[1]`=1 after the 3rd visit of ch1, ≤2+24 clocks; one event {1,1}.
- `IN[2]` high for 2 visits, then low → `OUT[2]` stays 0, `ctr[2]` returns to 0, no event.
- `CFG_WE` with addr 0, data 0; toggle `IN[0]` → `OUT[0]` frozen, no events. Write data 1 → next visit updates `OUT[0]`.
- `EVT_READY`=0; 5 changes with FIFO_EN (2 changes without) → first 4 (1) events kept in order, `EVT_OVF`=1. `OVF_CLR` → 0.
- `CFG_WE` to ch3 on ch3's deciding visit cycle → `OUT[3]` unchanged, `ctr[3]`=0, no event.
- `RST_N` low for one cycle while events are pending and counts are mid-run → all outputs at reset values the next cycle.
